// File: rtl/tcdm_mem_bank.sv
// TCDM slave-side SRAM bank: req/gnt request channel, byte-masked writes, fixed-latency
// in-order responses buffered in a credit-bounded FIFO so the master may backpressure.
module tcdm_mem_bank #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned BE_WIDTH   = DATA_WIDTH / 8,
    parameter int unsigned NUM_WORDS  = 1024,
    parameter int unsigned LATENCY    = 1,
    parameter int unsigned RSP_DEPTH  = 2
) (
    input  logic                  clk_i,
    input  logic                  resetn_i,
    input  logic                  req_i,
    output logic                  gnt_o,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic                  wen_i,
    input  logic [BE_WIDTH-1:0]   be_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic [DATA_WIDTH-1:0] r_data_o,
    output logic                  r_valid_o,
    input  logic                  r_ready_i
);

    localparam int unsigned OFF_W = $clog2(BE_WIDTH);
    localparam int unsigned IDX_W = $clog2(NUM_WORDS);
    localparam int unsigned CNT_W = $clog2(RSP_DEPTH + 1);
    localparam int unsigned PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;

    logic [DATA_WIDTH-1:0] r_mem [NUM_WORDS];
    logic [DATA_WIDTH-1:0] r_fifo [RSP_DEPTH];
    logic [CNT_W-1:0]      r_outstanding;
    logic [CNT_W-1:0]      r_fifo_cnt;
    logic [PTR_W-1:0]      r_wptr;
    logic [PTR_W-1:0]      r_rptr;

    logic [IDX_W-1:0]      w_idx;
    logic                  w_accept;
    logic                  w_pop;
    logic                  w_push_vld;
    logic [DATA_WIDTH-1:0] w_push_data;
    logic [DATA_WIDTH-1:0] w_rsp_data;
    logic                  w_unused;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Byte-offset and upper address bits are intentionally don't-care.
    assign w_unused   = ^addr_i;
    assign w_idx      = addr_i[OFF_W +: IDX_W];

    assign gnt_o      = req_i && resetn_i && (r_outstanding < CNT_W'(RSP_DEPTH));
    assign w_accept   = req_i && gnt_o;
    assign w_rsp_data = wen_i ? '0 : r_mem[w_idx];

    assign r_valid_o  = (r_fifo_cnt != '0);
    assign r_data_o   = r_valid_o ? r_fifo[r_rptr] : '0;
    assign w_pop      = r_valid_o && r_ready_i;

    always_ff @(posedge clk_i) begin
        if (w_accept && wen_i) begin
            for (int b = 0; b < BE_WIDTH; b++) begin
                if (be_i[b]) r_mem[w_idx][8*b +: 8] <= data_i[8*b +: 8];
            end
        end
    end

    // A pop frees its credit only from the following cycle onward.
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            r_outstanding <= '0;
        end else if (w_accept && !w_pop) begin
            r_outstanding <= r_outstanding + CNT_W'(1);
        end else if (!w_accept && w_pop) begin
            r_outstanding <= r_outstanding - CNT_W'(1);
        end
    end

    generate
        if (LATENCY == 1) begin : g_direct
            assign w_push_vld  = w_accept;
            assign w_push_data = w_rsp_data;
        end else begin : g_pipe
            logic [LATENCY-2:0]    r_pipe_vld;
            logic [DATA_WIDTH-1:0] r_pipe_data [LATENCY-1];

            always_ff @(posedge clk_i or negedge resetn_i) begin
                if (!resetn_i) begin
                    r_pipe_vld <= '0;
                end else begin
                    r_pipe_vld[0] <= w_accept;
                    for (int s = 1; s < LATENCY - 1; s++) r_pipe_vld[s] <= r_pipe_vld[s-1];
                end
            end

            always_ff @(posedge clk_i) begin
                r_pipe_data[0] <= w_rsp_data;
                for (int s = 1; s < LATENCY - 1; s++) r_pipe_data[s] <= r_pipe_data[s-1];
            end

            assign w_push_vld  = r_pipe_vld[LATENCY-2];
            assign w_push_data = r_pipe_data[LATENCY-2];
        end
    endgenerate

    // The credit bound guarantees a push never lands on a full FIFO.
    always_ff @(posedge clk_i) begin
        if (w_push_vld) r_fifo[r_wptr] <= w_push_data;
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_fifo_cnt <= '0;
        end else begin
            if (w_push_vld) r_wptr <= ptr_inc(r_wptr);
            if (w_pop)      r_rptr <= ptr_inc(r_rptr);
            if (w_push_vld && !w_pop) begin
                r_fifo_cnt <= r_fifo_cnt + CNT_W'(1);
            end else if (!w_push_vld && w_pop) begin
                r_fifo_cnt <= r_fifo_cnt - CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_tcdm_mem_bank.sv
// Bench for tcdm_mem_bank: two instances (LATENCY=1/RSP_DEPTH=2 and LATENCY=3/RSP_DEPTH=4)
// checked every cycle against a transaction-level memory + timed response queue model.
module tb_tcdm_mem_bank;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetn;
    logic        req    [2];
    logic        wen    [2];
    logic        rready [2];
    logic        gnt    [2];
    logic        rvalid [2];
    logic [31:0] addr   [2];
    logic [31:0] wdata  [2];
    logic [31:0] rdata  [2];
    logic [3:0]  be     [2];

    tcdm_mem_bank #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .NUM_WORDS(1024), .LATENCY(1), .RSP_DEPTH(2)
    ) u_dut_l1 (
        .clk_i(clk), .resetn_i(resetn), .req_i(req[0]), .gnt_o(gnt[0]), .addr_i(addr[0]),
        .wen_i(wen[0]), .be_i(be[0]), .data_i(wdata[0]), .r_data_o(rdata[0]),
        .r_valid_o(rvalid[0]), .r_ready_i(rready[0])
    );

    tcdm_mem_bank #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .NUM_WORDS(1024), .LATENCY(3), .RSP_DEPTH(4)
    ) u_dut_l3 (
        .clk_i(clk), .resetn_i(resetn), .req_i(req[1]), .gnt_o(gnt[1]), .addr_i(addr[1]),
        .wen_i(wen[1]), .be_i(be[1]), .data_i(wdata[1]), .r_data_o(rdata[1]),
        .r_valid_o(rvalid[1]), .r_ready_i(rready[1])
    );

    // Reference model: word memory plus queue of (data, cycle it becomes visible).
    logic [31:0] mm [2][1024];
    logic [31:0] qd [2][8];
    int          qt [2][8];
    int          qh [2];
    int          qn [2];
    int          now;
    bit          last_acc [2];
    logic        obs_v    [2];
    logic [31:0] obs_d    [2];
    int          n_vec = 0;
    int          n_err = 0;

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    function automatic int dep_of(input int k);
        return (k == 0) ? 2 : 4;
    endfunction

    task automatic chk(input string tag, input int k, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s dut%0d cycle %0d: observed 0x%0h expected 0x%0h", tag, k, now, got, exp);
        end
    endtask

    task automatic set_req(input int k, input bit r, input bit w, input logic [31:0] a,
                           input logic [3:0] b, input logic [31:0] d);
        req[k]   = r;
        wen[k]   = w;
        addr[k]  = a;
        be[k]    = b;
        wdata[k] = d;
    endtask

    task automatic tick();
        bit acc [2];
        bit pop [2];
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            bit          eg;
            bit          ev;
            logic [31:0] ed;
            eg = req[k] && (qn[k] < dep_of(k));
            ev = (qn[k] > 0) && (now >= qt[k][qh[k]]);
            ed = ev ? qd[k][qh[k]] : 32'h0;
            chk("gnt", k, {31'b0, gnt[k]}, {31'b0, eg});
            chk("r_valid", k, {31'b0, rvalid[k]}, {31'b0, ev});
            chk("r_data", k, rdata[k], ed);
            obs_v[k] = rvalid[k];
            obs_d[k] = rdata[k];
            acc[k]   = req[k] && eg;
            pop[k]   = ev && rready[k];
        end
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (pop[k]) begin
                qh[k] = (qh[k] + 1) % 8;
                qn[k] = qn[k] - 1;
            end
            if (acc[k]) begin
                int w;
                int t;
                w = int'((addr[k] >> 2) & 32'h3FF);
                t = (qh[k] + qn[k]) % 8;
                if (wen[k]) begin
                    for (int b = 0; b < 4; b++)
                        if (be[k][b]) mm[k][w][8*b +: 8] = wdata[k][8*b +: 8];
                    qd[k][t] = 32'h0;
                end else begin
                    qd[k][t] = mm[k][w];
                end
                qt[k][t] = now + lat_of(k);
                qn[k] = qn[k] + 1;
            end
            last_acc[k] = acc[k];
        end
        now++;
        #1;
    endtask

    task automatic do_reset();
        req[0] = 1'b1;
        req[1] = 1'b1;
        resetn = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("rst_gnt", k, {31'b0, gnt[k]}, 32'h0);
            chk("rst_r_valid", k, {31'b0, rvalid[k]}, 32'h0);
            chk("rst_r_data", k, rdata[k], 32'h0);
            qh[k] = 0;
            qn[k] = 0;
        end
        @(posedge clk);
        now++;
        #1;
        resetn = 1'b1;
        req[0] = 1'b0;
        req[1] = 1'b0;
    endtask

    initial begin
        logic [31:0] a3 [3];
        logic [31:0] v;
        int          i;
        int          first_pop;
        int          third;
        int          nv;
        int          first_v;
        int          last_v;
        int          ngnt [2];
        int          nrsp [2];

        now = 0;
        resetn = 1'b1;
        for (int k = 0; k < 2; k++) begin
            set_req(k, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
            rready[k] = 1'b1;
            qh[k] = 0;
            qn[k] = 0;
        end
        #1;
        do_reset();

        // Give every word used below a defined value.
        for (int w = 0; w < 16; w++) begin
            for (int k = 0; k < 2; k++) set_req(k, 1'b1, 1'b1, w * 4, 4'hF, $urandom);
            tick();
        end
        for (int k = 0; k < 2; k++) req[k] = 1'b0;
        repeat (4) tick();

        // Full-word write then read-back.
        set_req(0, 1'b1, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF);
        tick();
        chk("t1_wr_gnt", 0, {31'b0, last_acc[0]}, 32'h1);
        set_req(0, 1'b1, 1'b0, 32'h10, 4'h0, 32'h0);
        tick();
        chk("t1_wr_rsp_v", 0, {31'b0, obs_v[0]}, 32'h1);
        chk("t1_wr_rsp_d", 0, obs_d[0], 32'h0);
        req[0] = 1'b0;
        tick();
        chk("t1_rd_v", 0, {31'b0, obs_v[0]}, 32'h1);
        chk("t1_rd_d", 0, obs_d[0], 32'hDEADBEEF);

        // Byte-masked write merge.
        set_req(0, 1'b1, 1'b1, 32'h10, 4'b0101, 32'h11223344);
        tick();
        set_req(0, 1'b1, 1'b0, 32'h10, 4'h0, 32'h0);
        tick();
        req[0] = 1'b0;
        tick();
        chk("t2_merge", 0, obs_d[0], 32'hDE22BE44);
        repeat (2) tick();

        // Credit exhaustion with a held request.
        a3[0] = 32'h0;
        a3[1] = 32'h4;
        a3[2] = 32'h8;
        rready[0] = 1'b0;
        i = 0;
        for (int c = 0; c < 5; c++) begin
            set_req(0, 1'b1, 1'b0, a3[i], 4'h0, 32'h0);
            tick();
            if (last_acc[0]) i++;
        end
        chk("t3_held", 0, i, 2);
        rready[0] = 1'b1;
        first_pop = -1;
        third = -1;
        for (int c = 0; c < 8; c++) begin
            if (i < 3) set_req(0, 1'b1, 1'b0, a3[i], 4'h0, 32'h0);
            else req[0] = 1'b0;
            tick();
            if (obs_v[0] && first_pop < 0) first_pop = c;
            if (last_acc[0] && i == 2 && third < 0) third = c;
            if (last_acc[0]) i++;
        end
        chk("t3_first_pop", 0, first_pop, 0);
        chk("t3_third_gnt", 0, third, first_pop + 1);

        // Back-to-back reads on the deeper pipeline.
        nv = 0;
        first_v = -1;
        last_v = -1;
        for (int j = 0; j < 14; j++) begin
            if (j < 8) set_req(1, 1'b1, 1'b0, j * 4, 4'h0, 32'h0);
            else req[1] = 1'b0;
            tick();
            if (j < 8) chk("t4_gnt_every", 1, {31'b0, last_acc[1]}, 32'h1);
            if (obs_v[1]) begin
                nv++;
                if (first_v < 0) first_v = j;
                last_v = j;
            end
        end
        chk("t4_nvalid", 1, nv, 8);
        chk("t4_first_v", 1, first_v, 3);
        chk("t4_last_v", 1, last_v, 10);

        // Random traffic with random backpressure on both instances.
        for (int k = 0; k < 2; k++) begin
            ngnt[k] = 0;
            nrsp[k] = 0;
        end
        for (int c = 0; c < 400; c++) begin
            for (int k = 0; k < 2; k++) begin
                set_req(k, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                        ($urandom & 32'hFFFF_F003) | ($urandom_range(0, 15) << 2),
                        4'($urandom), $urandom);
                rready[k] = $urandom_range(0, 2) != 0;
            end
            tick();
            for (int k = 0; k < 2; k++) begin
                if (last_acc[k]) ngnt[k]++;
                if (obs_v[k] && rready[k]) nrsp[k]++;
            end
        end
        for (int k = 0; k < 2; k++) begin
            req[k] = 1'b0;
            rready[k] = 1'b1;
        end
        repeat (12) begin
            tick();
            for (int k = 0; k < 2; k++) if (obs_v[k]) nrsp[k]++;
        end
        for (int k = 0; k < 2; k++) chk("t5_rsp_count", k, nrsp[k], ngnt[k]);

        // Reset with responses outstanding; memory must survive.
        v = $urandom;
        set_req(0, 1'b1, 1'b1, 32'h14, 4'hF, v);
        tick();
        req[0] = 1'b0;
        repeat (2) tick();
        rready[0] = 1'b0;
        set_req(0, 1'b1, 1'b0, 32'h14, 4'h0, 32'h0);
        tick();
        set_req(0, 1'b1, 1'b0, 32'h18, 4'h0, 32'h0);
        tick();
        chk("t6_outstanding", 0, qn[0], 2);
        do_reset();
        rready[0] = 1'b1;
        set_req(0, 1'b1, 1'b0, 32'h14, 4'h0, 32'h0);
        tick();
        chk("t6_no_stale", 0, {31'b0, obs_v[0]}, 32'h0);
        chk("t6_gnt", 0, {31'b0, last_acc[0]}, 32'h1);
        req[0] = 1'b0;
        tick();
        chk("t6_rd_v", 0, {31'b0, obs_v[0]}, 32'h1);
        chk("t6_retained", 0, obs_d[0], v);
        repeat (2) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
